// File: rtl/vga_sink_monitor.sv
// VGA sink monitor: rebuilds pixel coordinates from HS/VS, checks timing, locks, checksums frames and captures a probe pixel.
// Optional blanking check (non-zero RGB outside the active area is an error) enabled by defining VGA_SINK_BLANK_CHECK_EN.
module vga_sink_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        VGA_CLK,
    input  logic        reset_n,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        locked,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_active,
    output logic        frame_valid,
    output logic [31:0] frame_sum,
    output logic [7:0]  probe_r,
    output logic [7:0]  probe_g,
    output logic [7:0]  probe_b,
    output logic [7:0]  err_count
);

    localparam logic [9:0] L_CNT_MAX  = 10'd1023;
    localparam logic [9:0] L_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_HSW_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0] L_HAS      = 10'(H_ACT_START);
    localparam logic [9:0] L_HAE      = 10'(H_ACT_START + H_ACTIVE);
    localparam logic [9:0] L_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_VSW      = 10'(V_SYNC);
    localparam logic [9:0] L_VAS      = 10'(V_ACT_START);
    localparam logic [9:0] L_VAE      = 10'(V_ACT_START + V_ACTIVE);
    localparam logic [7:0] L_LOCK     = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {ST_SEARCH, ST_SYNC_WAIT, ST_LOCKED} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_good, w_good_nxt;
    logic        r_hs_d, r_vs_d, r_vs_pend, r_dirty;
    logic [9:0]  r_h_cnt, r_v_cnt, w_h_cnt, w_v_cnt;
    logic        w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise, w_v_zero;
    logic        w_h_act, w_v_act, w_err, w_err_hit, w_frame_ok, w_probe_hit;
    logic [9:0]  w_rgb_sum;
    logic [31:0] r_acc;
    logic [7:0]  r_sh_r, r_sh_g, r_sh_b;

    // Counters are formed combinationally so the sample that shows the sync fall is already coordinate 0.
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        w_hs_fall = r_hs_d & ~VGA_HS;
        w_hs_rise = ~r_hs_d & VGA_HS;
        w_vs_fall = r_vs_d & ~VGA_VS;
        w_vs_rise = ~r_vs_d & VGA_VS;
        w_v_zero  = w_hs_fall & (w_vs_fall | r_vs_pend);

        w_h_cnt = r_h_cnt;
        if (w_hs_fall)                w_h_cnt = '0;
        else if (r_h_cnt != L_CNT_MAX) w_h_cnt = r_h_cnt + 10'd1;

        w_v_cnt = r_v_cnt;
        if (w_v_zero)                                w_v_cnt = '0;
        else if (w_hs_fall && r_v_cnt != L_CNT_MAX) w_v_cnt = r_v_cnt + 10'd1;

        w_h_act    = (w_h_cnt >= L_HAS) && (w_h_cnt < L_HAE);
        w_v_act    = (w_v_cnt >= L_VAS) && (w_v_cnt < L_VAE);
        pix_active = w_h_act & w_v_act;
        pix_x      = pix_active ? (w_h_cnt - L_HAS) : '0;
        pix_y      = pix_active ? (w_v_cnt - L_VAS) : '0;
        w_rgb_sum  = {2'b00, VGA_R} + {2'b00, VGA_G} + {2'b00, VGA_B};
        w_probe_hit = pix_active && (pix_x == probe_x) && (pix_y == probe_y);

        w_err = (w_hs_fall && r_h_cnt != L_H_LAST)
              | (w_hs_rise && r_h_cnt != L_HSW_LAST)
              | (w_vs_rise && w_v_cnt != L_VSW)
              | (w_vs_fall && r_v_cnt != L_V_LAST);
`ifdef VGA_SINK_BLANK_CHECK_EN
        w_err = w_err | (~pix_active & (|{VGA_R, VGA_G, VGA_B}));
`endif
        w_err_hit  = w_err & (r_state != ST_SEARCH);
        w_frame_ok = w_vs_fall & (r_state != ST_SEARCH) & ~r_dirty & ~w_err_hit;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_nxt = ST_SYNC_WAIT;
                    w_good_nxt  = '0;
                end
            end
            ST_SYNC_WAIT: begin
                if (w_vs_fall) begin
                    if (!w_frame_ok) begin
                        w_good_nxt = '0;
                    end else begin
                        w_good_nxt = r_good + 8'd1;
                        if (r_good + 8'd1 >= L_LOCK) w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_err_hit) w_state_nxt = ST_SEARCH;
            end
            default: w_state_nxt = ST_SEARCH;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge VGA_CLK) begin
        if (!reset_n) begin
            r_state     <= ST_SEARCH;
            r_good      <= '0;
            r_hs_d      <= 1'b0;
            r_vs_d      <= 1'b0;
            r_vs_pend   <= 1'b0;
            r_dirty     <= 1'b0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_acc       <= '0;
            r_sh_r      <= '0;
            r_sh_g      <= '0;
            r_sh_b      <= '0;
            frame_valid <= 1'b0;
            frame_sum   <= '0;
            probe_r     <= '0;
            probe_g     <= '0;
            probe_b     <= '0;
            err_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_good    <= w_good_nxt;
            r_hs_d    <= VGA_HS;
            r_vs_d    <= VGA_VS;
            r_h_cnt   <= w_h_cnt;
            r_v_cnt   <= w_v_cnt;
            // A VS fall between HS falls zeroes v_cnt at the next HS fall.
            if (w_hs_fall)      r_vs_pend <= 1'b0;
            else if (w_vs_fall) r_vs_pend <= 1'b1;
            if (w_vs_fall)      r_dirty <= 1'b0;
            else if (w_err_hit) r_dirty <= 1'b1;
            if (w_vs_fall)       r_acc <= '0;
            else if (pix_active) r_acc <= r_acc + {22'd0, w_rgb_sum};
            if (w_probe_hit) begin
                r_sh_r <= VGA_R;
                r_sh_g <= VGA_G;
                r_sh_b <= VGA_B;
            end
            frame_valid <= w_frame_ok;
            if (w_frame_ok) begin
                frame_sum <= r_acc;
                probe_r   <= r_sh_r;
                probe_g   <= r_sh_g;
                probe_b   <= r_sh_b;
            end
            if (w_err_hit && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    assign locked = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_vga_sink_monitor.sv
// Scoreboard bench for vga_sink_monitor using a reduced 40x20 timing so many frames fit in a short run.
module tb_vga_sink_monitor;

    localparam int HT = 40, HSW = 4, HAS = 8, HA = 24;
    localparam int VT = 20, VSW = 2, VAS = 4, VA = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hs = 1'b1, vs = 1'b1;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic [9:0]  px = '0, py = '0;
    logic        locked, pix_active, frame_valid;
    logic [9:0]  pix_x, pix_y;
    logic [31:0] frame_sum;
    logic [7:0]  probe_r, probe_g, probe_b, err_count;

    always #5 clk = ~clk;

    vga_sink_monitor #(
        .H_TOTAL(HT), .H_SYNC(HSW), .H_ACT_START(HAS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VSW), .V_ACT_START(VAS), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .VGA_CLK(clk), .reset_n(reset_n), .VGA_HS(hs), .VGA_VS(vs),
        .VGA_R(r), .VGA_G(g), .VGA_B(b), .probe_x(px), .probe_y(py),
        .locked(locked), .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
        .frame_valid(frame_valid), .frame_sum(frame_sum),
        .probe_r(probe_r), .probe_g(probe_g), .probe_b(probe_b), .err_count(err_count)
    );

    typedef struct {
        logic [31:0] sum;
        logic [7:0]  pr, pg, pb;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_pr = '0, m_pg = '0, m_pb = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    // Each frame_valid pulse is matched against the oldest expected frame.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("valid_unexpected", {31'd0, frame_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("frame_sum", frame_sum, e.sum);
                check("probe_r", {24'd0, probe_r}, {24'd0, e.pr});
                check("probe_g", {24'd0, probe_g}, {24'd0, e.pg});
                check("probe_b", {24'd0, probe_b}, {24'd0, e.pb});
            end
        end
    end

    task automatic pixel(input int mode, input int col, input int row,
                         output logic [7:0] pr, output logic [7:0] pg, output logic [7:0] pb);
        case (mode)
            0: begin pr = 8'd1;   pg = 8'd1;   pb = 8'd1; end
            1: begin pr = 8'd255; pg = 8'd255; pb = 8'd0; end
            default: begin pr = 8'(col * 7); pg = 8'(row * 11); pb = 8'(col + row); end
        endcase
    endtask

    // One frame starting with the VS fall; expectation pushed when exp_v is set.
    task automatic drive_frame(input int mode, input bit exp_v, input int bad_len_line,
                               input int bad_hs_first, input int bad_hs_num,
                               input int glitch_line, input int rst_line, input bit pix_chk);
        logic [31:0] s;
        exp_t        e;
        s = '0;
        for (int line = 0; line < VT; line++) begin
            int len, hw;
            len = (line == bad_len_line) ? HT - 1 : HT;
            hw  = (line >= bad_hs_first && line < bad_hs_first + bad_hs_num) ? HSW - 1 : HSW;
            for (int h = 0; h < len; h++) begin
                bit act, do_rst;
                act    = (h >= HAS && h < HAS + HA && line >= VAS && line < VAS + VA);
                do_rst = (line == rst_line && h == 20);
                hs = (h < hw) ? 1'b0 : 1'b1;
                vs = (line < VSW) ? 1'b0 : 1'b1;
                if (act) begin
                    pixel(mode, h - HAS, line - VAS, r, g, b);
                    s = s + 32'(r) + 32'(g) + 32'(b);
                    if (h - HAS == int'(px) && line - VAS == int'(py)) begin
                        m_pr = r; m_pg = g; m_pb = b;
                    end
                end else begin
                    r = '0; g = '0; b = '0;
                    if (line == glitch_line && h == 10) r = 8'd1;
                end
                @(negedge clk);
                if (pix_chk && line == VAS + 2) begin
                    if (h == HAS - 1) begin
                        check("pix_active_pre", {31'd0, pix_active}, 32'd0);
                        check("pix_x_pre", {22'd0, pix_x}, 32'd0);
                    end
                    if (h == HAS + 5) begin
                        check("pix_active_mid", {31'd0, pix_active}, 32'd1);
                        check("pix_x_mid", {22'd0, pix_x}, 32'd5);
                        check("pix_y_mid", {22'd0, pix_y}, 32'd2);
                    end
                    if (h == HAS + HA - 1) check("pix_x_last", {22'd0, pix_x}, 32'(HA - 1));
                    if (h == HAS + HA)     check("pix_active_post", {31'd0, pix_active}, 32'd0);
                end
                if (do_rst) reset_n = 1'b0;
                @(posedge clk);
                #1;
                if (do_rst) begin
                    reset_n = 1'b1;
                    m_pr = '0; m_pg = '0; m_pb = '0;
                    check("rst_locked", {31'd0, locked}, 32'd0);
                    check("rst_valid", {31'd0, frame_valid}, 32'd0);
                    check("rst_sum", frame_sum, 32'd0);
                    check("rst_probe_r", {24'd0, probe_r}, 32'd0);
                    check("rst_probe_g", {24'd0, probe_g}, 32'd0);
                    check("rst_probe_b", {24'd0, probe_b}, 32'd0);
                    check("rst_err", {24'd0, err_count}, 32'd0);
                    check("rst_pix_active", {31'd0, pix_active}, 32'd0);
                    check("rst_pix_xy", {12'd0, pix_x, pix_y}, 32'd0);
                end
            end
        end
        if (exp_v) begin
            e.sum = s; e.pr = m_pr; e.pg = m_pg; e.pb = m_pb;
            q.push_back(e);
        end
    endtask

    initial begin
        bit glitch_exp_v;
`ifdef VGA_SINK_BLANK_CHECK_EN
        glitch_exp_v = 1'b0;
`else
        glitch_exp_v = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_err", {24'd0, err_count}, 32'd0);
        check("reset_sum", frame_sum, 32'd0);
        check("reset_valid", {31'd0, frame_valid}, 32'd0);
        check("reset_probe_r", {24'd0, probe_r}, 32'd0);
        reset_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end

        drive_frame(0, 1, -1, -1, 0, -1, -1, 1);
        check("lock_after_f1", {31'd0, locked}, 32'd0);
        drive_frame(0, 1, -1, -1, 0, -1, -1, 0);
        check("lock_after_f2", {31'd0, locked}, 32'd0);
        drive_frame(1, 1, -1, -1, 0, -1, -1, 0);
        check("locked_f3", {31'd0, locked}, 32'd1);
        px = 10'd5; py = 10'd3;
        drive_frame(2, 1, -1, -1, 0, -1, -1, 0);
        check("err_clean", {24'd0, err_count}, 32'd0);

        drive_frame(0, 0, 10, -1, 0, -1, -1, 0);
        check("err_short_line", {24'd0, err_count}, 32'd1);
        check("unlock_short_line", {31'd0, locked}, 32'd0);
        drive_frame(2, 1, -1, -1, 0, -1, -1, 0);
        drive_frame(1, 1, -1, -1, 0, -1, -1, 0);
        drive_frame(0, glitch_exp_v, -1, -1, 0, 1, -1, 0);
`ifdef VGA_SINK_BLANK_CHECK_EN
        check("blank_err", {24'd0, err_count}, 32'd2);
        check("blank_unlock", {31'd0, locked}, 32'd0);
`else
        check("relock", {31'd0, locked}, 32'd1);
        check("blank_ignored", {24'd0, err_count}, 32'd1);
`endif

        drive_frame(0, 0, -1, -1, 0, -1, 10, 0);
        check("post_rst_locked", {31'd0, locked}, 32'd0);
        drive_frame(2, 0, -1, 5, 3, -1, -1, 0);
        check("err_hs_width3", {24'd0, err_count}, 32'd3);
        drive_frame(2, 1, -1, -1, 0, -1, -1, 0);
        for (int f = 0; f < 15; f++) drive_frame(1, 0, -1, 0, VT, -1, -1, 0);
        hs = 1'b1; vs = 1'b1; r = '0; g = '0; b = '0;
        repeat (10) begin @(posedge clk); #1; end
        check("err_saturate", {24'd0, err_count}, 32'd255);
        check("pending_valid", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
